// File: rtl/coffee_pkg.sv
// Shared types for the coffee order controller: selection codes, coin codes,
// FSM state encoding and the credit arithmetic helpers.
package coffee_pkg;

  typedef enum logic [1:0] {
    FlavEspresso   = 2'b00,
    FlavCappuccino = 2'b01,
    FlavLatte      = 2'b10,
    FlavMocha      = 2'b11
  } flavour_e;

  typedef enum logic [1:0] {
    SugarNone = 2'b00,
    SugarLow  = 2'b01,
    SugarMed  = 2'b10,
    SugarHigh = 2'b11
  } sugar_e;

  typedef enum logic [1:0] {
    Coin5  = 2'b00,
    Coin10 = 2'b01,
    Coin20 = 2'b10,
    Coin50 = 2'b11
  } coin_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCredit  = 3'd1,
    StIssue   = 3'd2,
    StBrewing = 3'd3,
    StRefund  = 3'd4
  } state_e;

  localparam logic [7:0] CreditMax = 8'd255;

  // Credit units carried by a coin code.
  function automatic logic [7:0] coin_to_credit(input logic [1:0] code);
    logic [7:0] val;
    case (code)
      Coin5:   val = 8'd5;
      Coin10:  val = 8'd10;
      Coin20:  val = 8'd20;
      default: val = 8'd50;
    endcase
    return val;
  endfunction

  // Credit addition that clamps at the register limit instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? CreditMax : sum[7:0];
  endfunction

endpackage

// File: rtl/coffee_order_ctrl_if.sv
// Order handshake between the controller (master) and the coffee maker (slave).
interface coffee_order_ctrl_if;
  logic       order_valid;
  logic       order_ready;
  logic [1:0] order_flavour;
  logic [1:0] order_sugar;
  logic       brew_done;

  modport master (
    output order_valid,
    output order_flavour,
    output order_sugar,
    input  order_ready,
    input  brew_done
  );

  modport slave (
    input  order_valid,
    input  order_flavour,
    input  order_sugar,
    output order_ready,
    output brew_done
  );
endinterface

// File: rtl/coffee_price_lut.sv
// Flavour-to-price lookup, purely combinational.
module coffee_price_lut
  import coffee_pkg::*;
#(
  parameter logic [7:0] PRICE_ESPRESSO   = 8'd30,
  parameter logic [7:0] PRICE_CAPPUCCINO = 8'd40,
  parameter logic [7:0] PRICE_LATTE      = 8'd40,
  parameter logic [7:0] PRICE_MOCHA      = 8'd50
) (
  input  logic [1:0] flavour,
  output logic [7:0] price
);

  // Decode the selected flavour to its price.
  always_comb begin
    price = PRICE_ESPRESSO;
    unique case (flavour)
      FlavEspresso:   price = PRICE_ESPRESSO;
      FlavCappuccino: price = PRICE_CAPPUCCINO;
      FlavLatte:      price = PRICE_LATTE;
      FlavMocha:      price = PRICE_MOCHA;
    endcase
  end

endmodule

// File: rtl/coffee_order_ctrl.sv
// Coffee order controller: collects coins, validates selections against price,
// issues orders to the maker and returns change.
// Optional feature macro: COFFEE_CHANGE_EN enables change output, refund on
// cancel/timeout and refund of residual credit after a brew. Without it the
// change outputs stay 0 and residual credit is kept for the next order.
module coffee_order_ctrl
  import coffee_pkg::*;
#(
  parameter logic [7:0]  PRICE_ESPRESSO   = 8'd30,
  parameter logic [7:0]  PRICE_CAPPUCCINO = 8'd40,
  parameter logic [7:0]  PRICE_LATTE      = 8'd40,
  parameter logic [7:0]  PRICE_MOCHA      = 8'd50,
  parameter logic [15:0] IDLE_TIMEOUT     = 16'd1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_valid,
  input  logic [1:0]                 coin_value,
  input  logic                       sel_valid,
  input  logic [1:0]                 sel_flavour,
  input  logic [1:0]                 sel_sugar,
  input  logic                       cancel,
  coffee_order_ctrl_if.master        maker,
  output logic [7:0]                 credit,
  output logic                       change_valid,
  output logic [7:0]                 change_amount,
  output logic                       err_funds,
  output logic                       busy
);

`ifdef COFFEE_CHANGE_EN
  localparam bit ChangeEn = 1'b1;
`else
  localparam bit ChangeEn = 1'b0;
`endif

  state_e      state_q;
  logic [7:0]  credit_q;
  logic        order_valid_q;
  logic [1:0]  order_flavour_q;
  logic [1:0]  order_sugar_q;
  logic        change_valid_q;
  logic [7:0]  change_amount_q;
  logic        err_funds_q;
  logic        busy_q;
  logic        brew_q;
  logic [15:0] idle_cnt_q;

  logic [7:0]  price;
  logic [7:0]  coin_amt;
  logic [7:0]  credit_sum;
  logic        sel_ok;
  logic        brew_rise;
  logic        coin_return;
  logic        activity;
  logic [15:0] idle_next;

  coffee_price_lut #(
    .PRICE_ESPRESSO   (PRICE_ESPRESSO),
    .PRICE_CAPPUCCINO (PRICE_CAPPUCCINO),
    .PRICE_LATTE      (PRICE_LATTE),
    .PRICE_MOCHA      (PRICE_MOCHA)
  ) u_price_lut (
    .flavour (sel_flavour),
    .price   (price)
  );

  // Coin is credited before the price check so coin+select in one cycle works.
  always_comb begin
    coin_amt    = coin_valid ? coin_to_credit(coin_value) : 8'd0;
    credit_sum  = sat_add(credit_q, coin_amt);
    sel_ok      = (credit_sum >= price);
    brew_rise   = maker.brew_done & ~brew_q;
    coin_return = ChangeEn & coin_valid;
    activity    = coin_valid | sel_valid;
    idle_next   = idle_cnt_q + 16'd1;
  end

  // Order FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= StIdle;
      credit_q        <= 8'd0;
      order_valid_q   <= 1'b0;
      order_flavour_q <= 2'b00;
      order_sugar_q   <= 2'b00;
      change_valid_q  <= 1'b0;
      change_amount_q <= 8'd0;
      err_funds_q     <= 1'b0;
      busy_q          <= 1'b0;
      brew_q          <= 1'b0;
      idle_cnt_q      <= 16'd0;
    end else begin
      change_valid_q  <= 1'b0;
      change_amount_q <= 8'd0;
      err_funds_q     <= 1'b0;
      brew_q          <= maker.brew_done;
      case (state_q)
        StIdle: begin
          idle_cnt_q <= 16'd0;
          if (coin_valid) begin
            credit_q <= credit_sum;
            state_q  <= StCredit;
          end
          // Nothing has been paid yet, so any selection is short of funds.
          if (sel_valid) err_funds_q <= 1'b1;
        end
        StCredit: begin
          if (cancel && ChangeEn) begin
            credit_q        <= credit_sum;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_sum;
            idle_cnt_q      <= 16'd0;
            state_q         <= StRefund;
          end else if (sel_valid && sel_ok) begin
            credit_q        <= credit_sum - price;
            order_flavour_q <= sel_flavour;
            order_sugar_q   <= sel_sugar;
            order_valid_q   <= 1'b1;
            busy_q          <= 1'b1;
            idle_cnt_q      <= 16'd0;
            state_q         <= StIssue;
          end else begin
            credit_q <= credit_sum;
            if (sel_valid) err_funds_q <= 1'b1;
            if (activity) begin
              idle_cnt_q <= 16'd0;
            end else if (ChangeEn && idle_next == IDLE_TIMEOUT) begin
              change_valid_q  <= 1'b1;
              change_amount_q <= credit_q;
              idle_cnt_q      <= 16'd0;
              state_q         <= StRefund;
            end else begin
              idle_cnt_q <= idle_next;
            end
          end
        end
        StIssue: begin
          idle_cnt_q <= 16'd0;
          if (coin_return) begin
            change_valid_q  <= 1'b1;
            change_amount_q <= coin_amt;
          end
          if (maker.order_ready) begin
            order_valid_q <= 1'b0;
            state_q       <= StBrewing;
          end
        end
        StBrewing: begin
          idle_cnt_q <= 16'd0;
          if (brew_rise) begin
            busy_q <= 1'b0;
            if (ChangeEn) begin
              // A coin arriving on the done edge is folded into the refund.
              credit_q <= credit_sum;
              if (credit_sum != 8'd0) begin
                change_valid_q  <= 1'b1;
                change_amount_q <= credit_sum;
                state_q         <= StRefund;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              state_q <= (credit_q != 8'd0) ? StCredit : StIdle;
            end
          end else if (coin_return) begin
            change_valid_q  <= 1'b1;
            change_amount_q <= coin_amt;
          end
        end
        StRefund: begin
          idle_cnt_q <= 16'd0;
          credit_q   <= 8'd0;
          state_q    <= StIdle;
          if (coin_return) begin
            change_valid_q  <= 1'b1;
            change_amount_q <= coin_amt;
          end
        end
        default: begin
          state_q       <= StIdle;
          credit_q      <= 8'd0;
          order_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          idle_cnt_q    <= 16'd0;
        end
      endcase
    end
  end

  assign maker.order_valid   = order_valid_q;
  assign maker.order_flavour = order_flavour_q;
  assign maker.order_sugar   = order_sugar_q;
  assign credit              = credit_q;
  assign change_valid        = change_valid_q;
  assign change_amount       = change_amount_q;
  assign err_funds           = err_funds_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Self-checking bench for coffee_order_ctrl; expectations follow the
// COFFEE_CHANGE_EN build the bench is compiled with.
module tb_coffee_order_ctrl;

  localparam logic [15:0] Timeout = 16'd20;
`ifdef COFFEE_CHANGE_EN
  localparam bit ChangeEn = 1'b1;
`else
  localparam bit ChangeEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_flavour;
  logic [1:0] sel_sugar;
  logic       cancel;
  logic [7:0] credit;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       err_funds;
  logic       busy;

  coffee_order_ctrl_if maker ();

  coffee_order_ctrl #(
    .IDLE_TIMEOUT (Timeout)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .sel_valid     (sel_valid),
    .sel_flavour   (sel_flavour),
    .sel_sugar     (sel_sugar),
    .cancel        (cancel),
    .maker         (maker),
    .credit        (credit),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .err_funds     (err_funds),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] change_q[$];
  logic [3:0] order_q[$];
  logic [7:0] coin_tab [4] = '{8'd5, 8'd10, 8'd20, 8'd50};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_value = code;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] f, input logic [1:0] s);
    sel_valid   = 1'b1;
    sel_flavour = f;
    sel_sugar   = s;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    maker.order_ready = 1'b0; maker.brew_done = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // Pops the expected change for this cycle, or expects silence if none queued.
  task automatic check_change(input string name);
    logic [7:0] want;
    checks++;
    if (change_q.size() != 0) begin
      want = change_q.pop_front();
      if (change_valid !== 1'b1 || change_amount !== want)
        $display("FAIL %s change: valid=%b amount=%0d, expected pulse of %0d",
                 name, change_valid, change_amount, want);
      else passed++;
    end else begin
      if (change_valid !== 1'b0 || change_amount !== 8'd0)
        $display("FAIL %s change: valid=%b amount=%0d, expected none",
                 name, change_valid, change_amount);
      else passed++;
    end
  endtask

  task automatic transfer(input string name);
    logic [3:0] want;
    int n = 0;
    while (maker.order_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (order_q.size() == 0) begin
      $display("FAIL %s order: offered %b, expected no order", name, maker.order_valid);
    end else begin
      want = order_q.pop_front();
      if (maker.order_valid !== 1'b1 || {maker.order_flavour, maker.order_sugar} !== want)
        $display("FAIL %s order: valid=%b sel=%b, expected valid=1 sel=%b", name,
                 maker.order_valid, {maker.order_flavour, maker.order_sugar}, want);
      else passed++;
    end
    maker.order_ready = 1'b1;
    step();
    maker.order_ready = 1'b0;
    checks++;
    if (maker.order_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s accept: order_valid=%b busy=%b, expected 0/1", name,
               maker.order_valid, busy);
    else passed++;
  endtask

  task automatic brew(input string name, input logic [7:0] residual);
    logic [7:0] want_credit;
    maker.brew_done = 1'b1;
    step();
    maker.brew_done = 1'b0;
    if (ChangeEn && residual != 8'd0) change_q.push_back(residual);
    check_change(name);
    checks++;
    if (busy !== 1'b0) $display("FAIL %s busy after brew: %b, expected 0", name, busy);
    else passed++;
    step();
    want_credit = ChangeEn ? 8'd0 : residual;
    checks++;
    if (change_valid !== 1'b0 || credit !== want_credit)
      $display("FAIL %s after brew: change_valid=%b credit=%0d, expected 0/%0d", name,
               change_valid, credit, want_credit);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    coin_valid = 1'b0; coin_value = 2'b00; sel_valid = 1'b0; sel_flavour = 2'b00;
    sel_sugar = 2'b00; cancel = 1'b0; maker.order_ready = 1'b0; maker.brew_done = 1'b0;
    step(); step();
    checks++;
    if ({credit, maker.order_valid, maker.order_flavour, maker.order_sugar, change_valid,
         change_amount, err_funds, busy} !== 25'd0)
      $display("FAIL reset outputs: credit=%0d ov=%b f=%b s=%b cv=%b ca=%0d err=%b busy=%b, expected all 0",
               credit, maker.order_valid, maker.order_flavour, maker.order_sugar,
               change_valid, change_amount, err_funds, busy);
    else passed++;
    rst = 1'b1;
    put_coin(2'b10);
    checks++;
    if (credit !== 8'd20) $display("FAIL reset first coin: credit=%0d, expected 20", credit);
    else passed++;
    rst = 1'b0;
    step();
    checks++;
    if (credit !== 8'd0 || change_valid !== 1'b0)
      $display("FAIL reset discard: credit=%0d change_valid=%b, expected 0/0", credit, change_valid);
    else passed++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_latte();
    apply_reset();
    put_coin(2'b10);
    put_coin(2'b10);
    checks++;
    if (credit !== 8'd40) $display("FAIL latte credit: %0d, expected 40", credit);
    else passed++;
    order_q.push_back({2'b10, 2'b01});
    select(2'b10, 2'b01);
    checks++;
    if (maker.order_valid !== 1'b1 || credit !== 8'd0 || busy !== 1'b1)
      $display("FAIL latte issue: ov=%b credit=%0d busy=%b, expected 1/0/1",
               maker.order_valid, credit, busy);
    else passed++;
    transfer("latte");
    brew("latte", 8'd0);
  endtask

  task automatic test_espresso_change();
    apply_reset();
    put_coin(2'b11);
    put_coin(2'b01);
    order_q.push_back({2'b00, 2'b10});
    select(2'b00, 2'b10);
    checks++;
    if (credit !== 8'd30 || maker.order_valid !== 1'b1)
      $display("FAIL espresso issue: credit=%0d ov=%b, expected 30/1", credit, maker.order_valid);
    else passed++;
    transfer("espresso");
    brew("espresso", 8'd30);
  endtask

  task automatic test_funds();
    apply_reset();
    select(2'b11, 2'b00);
    checks++;
    if (err_funds !== 1'b1 || credit !== 8'd0 || maker.order_valid !== 1'b0)
      $display("FAIL funds idle: err=%b credit=%0d ov=%b, expected 1/0/0",
               err_funds, credit, maker.order_valid);
    else passed++;
    put_coin(2'b10);
    select(2'b11, 2'b00);
    checks++;
    if (err_funds !== 1'b1 || credit !== 8'd20 || maker.order_valid !== 1'b0)
      $display("FAIL funds short: err=%b credit=%0d ov=%b, expected 1/20/0",
               err_funds, credit, maker.order_valid);
    else passed++;
    step();
    checks++;
    if (err_funds !== 1'b0 || credit !== 8'd20)
      $display("FAIL funds pulse: err=%b credit=%0d, expected 0/20", err_funds, credit);
    else passed++;
    coin_valid = 1'b1; coin_value = 2'b11;
    order_q.push_back({2'b11, 2'b10});
    select(2'b11, 2'b10);
    coin_valid = 1'b0;
    checks++;
    if (maker.order_valid !== 1'b1 || credit !== 8'd20 || err_funds !== 1'b0)
      $display("FAIL funds coin+sel: ov=%b credit=%0d err=%b, expected 1/20/0",
               maker.order_valid, credit, err_funds);
    else passed++;
    transfer("mocha");
    brew("mocha", 8'd20);
  endtask

  task automatic test_hold();
    int code;
    apply_reset();
    put_coin(2'b11);
    order_q.push_back({2'b01, 2'b11});
    select(2'b01, 2'b11);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1 && i < 9) begin
        code = (i - 1) / 2;
        coin_valid = 1'b1;
        coin_value = code[1:0];
        if (ChangeEn) change_q.push_back(coin_tab[code]);
      end
      step();
      coin_valid = 1'b0;
      checks++;
      if (maker.order_valid !== 1'b1 || maker.order_flavour !== 2'b01 ||
          maker.order_sugar !== 2'b11 || credit !== 8'd10)
        $display("FAIL hold cycle %0d: ov=%b f=%b s=%b credit=%0d, expected 1/01/11/10", i,
                 maker.order_valid, maker.order_flavour, maker.order_sugar, credit);
      else passed++;
      check_change("hold");
    end
    transfer("hold");
    brew("hold", 8'd10);
  endtask

  task automatic test_timeout_cancel();
    logic [7:0] got;
    logic [7:0] want;
    logic       found;
    int         n;
    apply_reset();
    put_coin(2'b01);
    if (ChangeEn) change_q.push_back(8'd10);
    found = 1'b0; n = 0; got = 8'd0;
    for (int i = 0; i < 2 * Timeout; i++) begin
      step();
      if (change_valid === 1'b1 && !found) begin
        found = 1'b1; n = i + 1; got = change_amount;
      end
    end
    checks++;
    if (change_q.size() != 0) begin
      want = change_q.pop_front();
      if (!found || n != int'(Timeout) || got !== want)
        $display("FAIL timeout: seen=%b after %0d cycles amount=%0d, expected %0d after %0d",
                 found, n, got, want, Timeout);
      else passed++;
    end else begin
      if (found) $display("FAIL timeout: change after %0d cycles, expected none", n);
      else passed++;
    end
    select(2'b00, 2'b00);
    want = ChangeEn ? 8'd0 : 8'd10;
    checks++;
    if (err_funds !== 1'b1 || credit !== want)
      $display("FAIL timeout after: err=%b credit=%0d, expected 1/%0d", err_funds, credit, want);
    else passed++;

    apply_reset();
    put_coin(2'b11);
    cancel = 1'b1;
    if (ChangeEn) change_q.push_back(8'd50);
    step();
    cancel = 1'b0;
    check_change("cancel");
    step();
    want = ChangeEn ? 8'd0 : 8'd50;
    checks++;
    if (credit !== want || change_valid !== 1'b0)
      $display("FAIL cancel after: credit=%0d cv=%b, expected %0d/0", credit, change_valid, want);
    else passed++;
  endtask

  task automatic test_cancel_vs_sel();
    logic [7:0] want;
    apply_reset();
    put_coin(2'b11);
    cancel = 1'b1;
    if (ChangeEn) change_q.push_back(8'd50);
    else order_q.push_back({2'b00, 2'b00});
    select(2'b00, 2'b00);
    cancel = 1'b0;
    check_change("cancel+sel");
    want = ChangeEn ? 8'd50 : 8'd20;
    checks++;
    if (maker.order_valid !== !ChangeEn || credit !== want)
      $display("FAIL cancel+sel: ov=%b credit=%0d, expected %b/%0d", maker.order_valid,
               credit, !ChangeEn, want);
    else passed++;
    if (order_q.size() != 0) transfer("cancel+sel");
  endtask

  task automatic test_saturate();
    logic [7:0] want;
    apply_reset();
    for (int i = 0; i < 6; i++) put_coin(2'b11);
    checks++;
    if (credit !== 8'd255) $display("FAIL saturate: credit=%0d, expected 255", credit);
    else passed++;
    cancel = 1'b1;
    if (ChangeEn) change_q.push_back(8'd255);
    step();
    cancel = 1'b0;
    check_change("saturate");
    step();
    want = ChangeEn ? 8'd0 : 8'd255;
    checks++;
    if (credit !== want) $display("FAIL saturate after: credit=%0d, expected %0d", credit, want);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    put_coin(2'b10);
    put_coin(2'b11);
    order_q.push_back({2'b11, 2'b00});
    select(2'b11, 2'b00);
    transfer("reset-mid");
    rst = 1'b0;
    step();
    checks++;
    if ({credit, maker.order_valid, change_valid, change_amount, err_funds, busy} !== 20'd0)
      $display("FAIL reset mid: credit=%0d ov=%b cv=%b ca=%0d err=%b busy=%b, expected all 0",
               credit, maker.order_valid, change_valid, change_amount, err_funds, busy);
    else passed++;
    rst = 1'b1;
    maker.brew_done = 1'b1;
    step();
    maker.brew_done = 1'b0;
    check_change("reset-mid");
    checks++;
    if (busy !== 1'b0 || credit !== 8'd0)
      $display("FAIL reset mid after: busy=%b credit=%0d, expected 0/0", busy, credit);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latte();
    test_espresso_change();
    test_funds();
    test_hold();
    test_timeout_cancel();
    test_cancel_vs_sel();
    test_saturate();
    test_reset_mid();
    checks++;
    if (change_q.size() != 0 || order_q.size() != 0)
      $display("FAIL scoreboard drain: %0d changes and %0d orders left, expected 0/0",
               change_q.size(), order_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
